// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
// Operation enum, opcode/funct fields and the buffered {instr, addr} entry.
package rv32i_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_XOR  = 4'd4,
    OP_BEQ  = 4'd5,
    OP_BNE  = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8,
    OP_LUI  = 4'd9,
    OP_SB   = 4'd10,
    OP_LBU  = 4'd11
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Request/response bundle between a requester and the instruction encoder.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// source holds payload stable while valid && !ready, ready never depends on valid.
interface rv32i_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err
  );
endinterface

// File: rtl/rv32i_instr_encoder_instr_pack.sv
// Combinational RV32I word builder: op + register fields + immediate -> word,
// plus flags for unknown op codes and immediates that do not fit their format.
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal,
  output logic        range_err
);

  logic i_ok;
  logic b_ok;
  logic j_ok;

  // Fits when all bits above the format's sign bit replicate it; B/J must be even.
  assign i_ok = (imm[31:11] == {21{imm[11]}});
  assign b_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign j_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];

  always_comb begin
    instr     = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (op_e'(op))
      OP_ADD:  instr = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      OP_SUB:  instr = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      OP_XOR:  instr = {F7_BASE, rs2, rs1, F3_XOR,     rd, OPC_OP};
      OP_AND:  instr = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_OP};
      OP_ADDI: begin
        instr     = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
        range_err = !i_ok;
      end
      OP_JALR: begin
        instr     = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
        range_err = !i_ok;
      end
      OP_LBU: begin
        instr     = {imm[11:0], rs1, F3_LBU, rd, OPC_LOAD};
        range_err = !i_ok;
      end
      OP_SB: begin
        instr     = {imm[11:5], rs2, rs1, F3_SB, imm[4:0], OPC_STORE};
        range_err = !i_ok;
      end
      OP_BEQ: begin
        instr     = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
        range_err = !b_ok;
      end
      OP_BNE: begin
        instr     = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
        range_err = !b_ok;
      end
      OP_JAL: begin
        instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        range_err = !j_ok;
      end
      OP_LUI:  instr = {imm[31:12], rd, OPC_LUI};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs requests into words, tags each with a running
// write address and buffers {instr, addr} in a 2-entry FIFO for a memory loader.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  rv32i_instr_encoder_if.slave  bus
);

  logic [31:0] pack_instr;
  logic        pack_illegal;
  logic        pack_range_err;

  entry_t      mem [2];
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] addr_cnt;
  logic        err_q;

  logic full;
  logic accept;
  logic enq;
  logic deq;

  instr_pack u_pack (
    .op        (bus.in_op),
    .rd        (bus.in_rd),
    .rs1       (bus.in_rs1),
    .rs2       (bus.in_rs2),
    .imm       (bus.in_imm),
    .instr     (pack_instr),
    .illegal   (pack_illegal),
    .range_err (pack_range_err)
  );

  // Full comes from the registered count, so a same-cycle dequeue never frees a slot.
  assign full          = (count == 2'd2);
  assign bus.in_ready  = rst_n && !full && !restart;
  assign accept        = bus.in_valid && bus.in_ready;
  assign enq           = accept && !pack_illegal;
  assign bus.out_valid = (count != 2'd0);
  assign deq           = bus.out_valid && bus.out_ready && !restart;
  assign bus.out_instr = mem[rd_ptr].instr;
  assign bus.out_addr  = mem[rd_ptr].addr;
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      addr_cnt <= BASE_ADDR;
      err_q    <= 1'b0;
      mem[0]   <= '{instr: 32'd0, addr: BASE_ADDR};
      mem[1]   <= '{instr: 32'd0, addr: BASE_ADDR};
    end else if (restart) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      addr_cnt <= BASE_ADDR;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= '{instr: pack_instr, addr: addr_cnt};
        wr_ptr      <= ~wr_ptr;
        addr_cnt    <= addr_cnt + ADDR_STEP;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && (pack_illegal || pack_range_err)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rv32i_instr_encoder.md
RV32I_INSTR_ENCODER -- requirements
Module: rv32i_instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'hBFC0_0000: first output write address after reset/restart.
REQ-002 Parameter ADDR_STEP, default 4: address increment per emitted word.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 restart  in  1  sync: flush buffer, reload address to BASE_ADDR.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted on in_valid&in_ready.
REQ-008 in_op  in  4  operation code (package enum).
REQ-009 in_rd / in_rs1 / in_rs2  in  5 each  register fields.
REQ-010 in_imm  in  32  byte-offset/immediate; LUI takes the full value, low 12 bits ignored.
REQ-011 out_valid  out  1  encoded word present.
REQ-012 out_ready  in  1  consumer (instruction-memory loader) accepts.
REQ-013 out_instr  out  32  encoded RV32I word.
REQ-014 out_addr  out  32  write address paired with out_instr.
REQ-015 err  out  1  sticky error flag.

Function
REQ-016 Supported ops: ADDI, ADD, SUB, AND, XOR, BEQ, BNE, JAL, JALR, LUI, SB, LBU; codes 12-15 illegal.
REQ-017 Encoding per RV32I formats: R (ADD f3 000/f7 0, SUB f3 000/f7 0x20, XOR f3 100, AND f3 111), I (ADDI/JALR/LBU f3 000/000/100), S (SB f3 000), B (BEQ 000, BNE 001), U (LUI), J (JAL).
REQ-018 Unused fields per format forced to zero; rs1/rs2 ignored where format lacks them.
REQ-019 Immediate range: I/S signed 12-bit, B signed 13-bit even, J signed 21-bit even; violation sets err, word still emitted with truncated immediate (bit0 dropped for B/J).
REQ-020 Illegal op: request consumed, nothing enqueued, err set.
REQ-021 2-entry FIFO of {instr, addr}; in_ready = !full && !restart.
REQ-022 Latency: accepted request appears on out_valid next cycle when FIFO was empty; no combinational path in_* -> out_*.
REQ-023 Full throughput: simultaneous enqueue and dequeue when full permitted only via in_ready; full FIFO with out_ready high still deasserts in_ready that cycle (registered full).
REQ-024 Address counter assigned at enqueue: word n gets BASE_ADDR + n*ADDR_STEP, mod 2^32 wrap; illegal ops do not advance it.
REQ-025 out_instr/out_addr stable while out_valid && !out_ready.
REQ-026 restart priority: FIFO emptied, counter reloaded, concurrent input not accepted, concurrent output handshake discarded; err unchanged.
REQ-027 err cleared only by reset.

Reset
REQ-028 rst_n low: FIFO empty, out_valid=0, in_ready=0 while asserted, err=0, address counter=BASE_ADDR, out_instr=0, out_addr=BASE_ADDR.
REQ-029 First cycle after rst_n release: in_ready=1; reset mid-transfer drops all buffered words.

Structure
REQ-030 Package rv32i_pkg holds op enum, 7-bit opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111), funct3/funct7 constants.
REQ-031 One combinational sub-module instr_pack: op+fields -> {instr, illegal, range_err}; FIFO and counter in top.

Verification
REQ-032 ADDI rd=1 rs1=0 imm=5 -> 0x00500093 at 0xBFC00000; ADD rd=3 rs1=1 rs2=2 -> 0x002081B3 at 0xBFC00004; SUB same -> 0x402081B3.
REQ-033 BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=1 imm=16 -> 0x010000EF; LUI rd=5 imm=0x12345000 -> 0x123452B7.
REQ-034 SB rs1=1 rs2=2 imm=3 -> 0x002081A3; LBU rd=4 rs1=1 imm=0 -> 0x0000C203; ADDI imm=4096 -> err=1, word emitted.
REQ-035 out_ready=0, three back-to-back requests -> two accepted, in_ready=0, third held; out_ready=1 -> in-order drain, addresses +4 each.
REQ-036 in_op=15 -> err=1, no out_valid, next legal word takes unadvanced address; restart with in_valid high -> input dropped, next word at 0xBFC00000.
REQ-037 rst_n pulsed low with FIFO full -> out_valid=0 immediately, err=0, first post-reset word at 0xBFC00000.
